priority_irq_latch: RTL and testbench
=====================================

Name: priority_irq_latch

Overview:
- Interrupt-style request capture stage feeding the priority encode path.
- Detects rising edges on eight raw request lines and latches them as pending bits.
- Selects the highest-priority unmasked pending source (bit 0 highest, bit 7 lowest) and presents its 3-bit code on a valid/ready handshake.
- Clears the pending bit when the consumer accepts the code, and flags overflow when a source re-fires while its previous request is still pending.

Parameters:
N, 8, number of request sources
CW, 3, code width; must equal clog2(N)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  synchronous active-low reset
din  input  N  raw request lines (level, synchronous to clk)
mask  input  N  1 = source excluded from selection (still latched)
ready  input  1  consumer accepts code this cycle
ovf_clr  input  1  clears all overflow flags
code  output  CW  selected source index
valid  output  1  code is valid
pending  output  N  latched, not-yet-accepted requests
overflow  output  N  sticky per-source overflow flags

Behaviour:
- Interface: one clock (clk); reset (rst_n) is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - pending=0, overflow=0, code=0, valid=0.
  - din_q loads din, so lines already high at reset release do not generate an edge.
  - Mid-operation reset drops any in-flight code without completing a handshake.
- Edge detect:
  - din_q registers din every cycle.
  - rise[i] = din[i] & ~din_q[i]. Level-high lines produce exactly one rise.
- Pending update at each edge:
  - pending[i] <= (pending[i] & ~clr[i]) | rise[i].
  - clr[i] = valid & ready & (code==i).
  - Set wins over clear in the same cycle.
  - mask does not block latching.
- Overflow:
  - overflow[i] <= 1 when rise[i] & pending[i] & ~clr[i].
  - Cleared by ovf_clr; a new overflow event in the same cycle as ovf_clr wins (flag stays 1).
- Selection:
  - elig = pending & ~mask, with bit code removed when valid & ready.
  - Lowest set index of elig wins.
- Output register:
  - Loads when valid=0 or (valid & ready).
  - If elig != 0: code <= winning index, valid <= 1.
  - Otherwise valid <= 0 and code holds its previous value.
  - While valid & ~ready: code and valid are held stable regardless of new requests, higher-priority arrivals, or mask changes. There is no retraction and no preemption.
- Latency:
  - Rise sampled at edge t sets pending after t.
  - Earliest valid=1 with that code is after edge t+1 (2 cycles from din change to valid).
- Throughput: with ready held at 1, one code per cycle; back-to-back codes are never the same source unless it re-fired.
- Masked-but-pending sources are served as soon as they are unmasked, subject to priority.
- All pending masked: valid=0; pending is retained.

Test Plan:
- Reset release with din=8'h81 held high, then din=8'h00 -> no pending, valid=0, no codes produced.
- From idle, din 8'h00->8'h24 for one cycle, ready=1 -> pending=8'h24 after 1 edge; code=2 valid=1 next cycle; code=5 the cycle after; then valid=0, pending=8'h00.
- Pulse din=8'hFF once, ready=1 continuously -> codes 0,1,2,...,7 on 8 consecutive cycles, then valid=0.
- Raise src 6 with ready=0, then raise src 1 while valid -> code stays 6 until ready=1; after that accept, code=1 next cycle.
- Src 3 pending, pulse din[3] again before acceptance -> overflow=8'h08. Assert ovf_clr -> overflow=0. Pulse din[3] in the same cycle it is accepted -> pending[3] stays 1, no overflow, code 3 re-issued.
- Src 0 and src 4 pending with mask=8'h01 -> code=4 served; then clear mask -> code=0 served; assert rst_n=0 while valid -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/priority_irq_latch.sv
// -----------------------------------------------------------------------------
// priority_irq_latch
//
// Purpose:
//   Interrupt-style request capture stage. Rising edges on N raw request lines
//   are latched as pending bits. The highest-priority unmasked pending source
//   (bit 0 highest) is presented as a CW-bit code on a valid/ready handshake.
//   Acceptance clears that source's pending bit. A source that re-fires while
//   its earlier request is still pending sets a sticky overflow flag.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   synchronous active-low reset
//   din       in   N   raw request lines (level, synchronous to clk)
//   mask      in   N   1 = source excluded from selection (still latched)
//   ready     in   1   consumer accepts the presented code this cycle
//   ovf_clr   in   1   clears all overflow flags
//   code      out  CW  selected source index
//   valid     out  1   code is valid
//   pending   out  N   latched, not-yet-accepted requests
//   overflow  out  N   sticky per-source overflow flags
// -----------------------------------------------------------------------------
module priority_irq_latch #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  din,
    input  logic [N-1:0]  mask,
    input  logic          ready,
    input  logic          ovf_clr,
    output logic [CW-1:0] code,
    output logic          valid,
    output logic [N-1:0]  pending,
    output logic [N-1:0]  overflow
);

    logic [N-1:0]  r_din_q;
    logic [N-1:0]  r_pending;
    logic [N-1:0]  r_overflow;
    logic [CW-1:0] r_code;
    logic          r_valid;

    logic [N-1:0]  w_rise;
    logic          w_accept;
    logic [N-1:0]  w_clr;
    logic [N-1:0]  w_pending_next;
    logic [N-1:0]  w_ovf_event;
    logic [N-1:0]  w_overflow_next;
    logic [N-1:0]  w_elig;
    logic [CW-1:0] w_sel_idx;
    logic          w_sel_any;
    logic          w_out_load;

    assign w_rise   = din & ~r_din_q;
    assign w_accept = r_valid & ready;

    // One-hot clear of the source whose code is being accepted this cycle.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_clr
            assign w_clr[gi] = w_accept && (r_code == CW'(gi));
        end
    endgenerate

    // A rise in the same cycle as the clear re-arms the bit (set wins).
    assign w_pending_next = (r_pending & ~w_clr) | w_rise;

    // Re-fire of a source that stays pending counts as overflow; a re-fire
    // coinciding with its own acceptance is a fresh request, not an overflow.
    assign w_ovf_event     = w_rise & r_pending & ~w_clr;
    assign w_overflow_next = (ovf_clr ? '0 : r_overflow) | w_ovf_event;

    // The source being accepted is dropped so it is not presented twice.
    assign w_elig = r_pending & ~mask & ~w_clr;

    // Lowest set index wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_sel_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_sel_idx = CW'(i);
            end
        end
    end

    assign w_sel_any = |w_elig;

    // Output stage only moves when empty or being drained: no retraction,
    // no preemption of a code the consumer has not yet taken.
    assign w_out_load = ~r_valid | w_accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Capturing din here stops lines already high at reset release
            // from being seen as rising edges.
            r_din_q    <= din;
            r_pending  <= '0;
            r_overflow <= '0;
            r_code     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_din_q    <= din;
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
            if (w_out_load) begin
                r_valid <= w_sel_any;
                if (w_sel_any) begin
                    r_code <= w_sel_idx;
                end
            end
        end
    end

    assign code     = r_code;
    assign valid    = r_valid;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_priority_irq_latch.sv
// -----------------------------------------------------------------------------
// tb_priority_irq_latch
//
// Directed bench for priority_irq_latch. Inputs are driven 1 ns after the
// rising edge and outputs are checked at that same point, so every check
// observes the state produced by the edge just taken.
// -----------------------------------------------------------------------------
module tb_priority_irq_latch;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [7:0] mask;
    logic       ready;
    logic       ovf_clr;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic [7:0] overflow;

    int n_checks;
    int n_pass;

    priority_irq_latch #(.N(8), .CW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .mask     (mask),
        .ready    (ready),
        .ovf_clr  (ovf_clr),
        .code     (code),
        .valid    (valid),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        $display("check %-16s observed %02h required %02h", tag, obs, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        din      = 8'h81;
        mask     = 8'h00;
        ready    = 1'b0;
        ovf_clr  = 1'b0;

        // ---- reset with lines 0 and 7 already high ----
        tick();
        chk("rst_pending", pending, 8'h00);
        chk("rst_overflow", overflow, 8'h00);
        chk("rst_valid", {7'd0, valid}, 8'h00);
        chk("rst_code", {5'd0, code}, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("rel_pending", pending, 8'h00);
        din = 8'h00;
        tick();
        chk("rel_pending2", pending, 8'h00);
        tick();
        chk("rel_valid", {7'd0, valid}, 8'h00);

        // ---- two sources, priority order 2 then 5 ----
        ready = 1'b1;
        din   = 8'h24;
        tick();
        chk("t2_pending", pending, 8'h24);
        chk("t2_valid0", {7'd0, valid}, 8'h00);
        din = 8'h00;
        tick();
        chk("t2_code2", {5'd0, code}, 8'h02);
        chk("t2_valid1", {7'd0, valid}, 8'h01);
        tick();
        chk("t2_code5", {5'd0, code}, 8'h05);
        chk("t2_pend20", pending, 8'h20);
        tick();
        chk("t2_valid_end", {7'd0, valid}, 8'h00);
        chk("t2_pend_end", pending, 8'h00);
        chk("t2_code_hold", {5'd0, code}, 8'h05);

        // ---- all eight, one code per cycle ----
        din = 8'hFF;
        tick();
        chk("t3_pending", pending, 8'hFF);
        din = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_code", {5'd0, code}, 8'(i));
            chk("t3_valid", {7'd0, valid}, 8'h01);
        end
        tick();
        chk("t3_valid_end", {7'd0, valid}, 8'h00);
        chk("t3_pend_end", pending, 8'h00);

        // ---- no preemption while stalled ----
        ready = 1'b0;
        din   = 8'h40;
        tick();
        tick();
        chk("t4_code6", {5'd0, code}, 8'h06);
        din = 8'h42;
        tick();
        chk("t4_pend42", pending, 8'h42);
        chk("t4_hold6a", {5'd0, code}, 8'h06);
        tick();
        chk("t4_hold6b", {5'd0, code}, 8'h06);
        chk("t4_hold_valid", {7'd0, valid}, 8'h01);
        ready = 1'b1;
        tick();
        chk("t4_code1", {5'd0, code}, 8'h01);
        chk("t4_pend02", pending, 8'h02);
        din = 8'h00;
        tick();
        chk("t4_valid_end", {7'd0, valid}, 8'h00);

        // ---- overflow, clear, clear-vs-event, re-fire on accept ----
        ready = 1'b0;
        din   = 8'h08;
        tick();
        din = 8'h00;
        tick();
        chk("t5_code3", {5'd0, code}, 8'h03);
        din = 8'h08;
        tick();
        chk("t5_ovf", overflow, 8'h08);
        din     = 8'h00;
        ovf_clr = 1'b1;
        tick();
        chk("t5_ovf_clr", overflow, 8'h00);
        din = 8'h08;
        tick();
        chk("t5_ovf_wins", overflow, 8'h08);
        din = 8'h00;
        tick();
        chk("t5_ovf_clr2", overflow, 8'h00);
        ovf_clr = 1'b0;
        din     = 8'h08;
        ready   = 1'b1;
        tick();
        chk("t5_refire_pend", pending, 8'h08);
        chk("t5_refire_ovf", overflow, 8'h00);
        chk("t5_refire_vld", {7'd0, valid}, 8'h00);
        din   = 8'h00;
        ready = 1'b0;
        tick();
        chk("t5_reissue", {5'd0, code}, 8'h03);
        chk("t5_reissue_v", {7'd0, valid}, 8'h01);
        ready = 1'b1;
        tick();
        chk("t5_drain_v", {7'd0, valid}, 8'h00);
        chk("t5_drain_p", pending, 8'h00);

        // ---- masking, unmask, reset while valid ----
        ready = 1'b0;
        mask  = 8'h01;
        din   = 8'h11;
        tick();
        chk("t6_pending", pending, 8'h11);
        din = 8'h00;
        tick();
        chk("t6_code4", {5'd0, code}, 8'h04);
        ready = 1'b1;
        tick();
        chk("t6_masked_v", {7'd0, valid}, 8'h00);
        chk("t6_masked_p", pending, 8'h01);
        ready = 1'b0;
        mask  = 8'h00;
        tick();
        chk("t6_code0", {5'd0, code}, 8'h00);
        chk("t6_valid0", {7'd0, valid}, 8'h01);
        rst_n = 1'b0;
        din   = 8'h02;
        tick();
        chk("t6_rst_valid", {7'd0, valid}, 8'h00);
        chk("t6_rst_pend", pending, 8'h00);
        chk("t6_rst_code", {5'd0, code}, 8'h00);
        chk("t6_rst_ovf", overflow, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("t6_post_pend", pending, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
